// File: rtl/comparator_chk_pkg.sv
// comparator_chk_pkg
//   Shared types and constants for the comparator response checker:
//   FSM state encoding and bit positions of the {gt,lt,eq} response word.
package comparator_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int RESP_W = 3;
  localparam int GT_BIT = 2;
  localparam int LT_BIT = 1;
  localparam int EQ_BIT = 0;

endpackage

// File: rtl/comparator_golden_model.sv
// comparator_golden_model
//   Combinational reference for an unsigned WIDTH-bit magnitude comparator.
//   Ports:
//     a_i    in  WIDTH   operand A
//     b_i    in  WIDTH   operand B
//     resp_o out 3       expected response, bit order {gt,lt,eq}
module comparator_golden_model
  import comparator_chk_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  output logic [RESP_W-1:0] resp_o
);

  always_comb begin
    resp_o         = '0;
    resp_o[GT_BIT] = (a_i > b_i);
    resp_o[LT_BIT] = (a_i < b_i);
    resp_o[EQ_BIT] = (a_i == b_i);
  end

endmodule

// File: rtl/comparator_response_checker.sv
// comparator_response_checker
//   Consumes one exhaustive sweep of {A,B} vectors with the comparator's
//   GT/LT/EQ responses, checks each response against the golden model,
//   checks that vectors arrive in sweep order (A in the MSBs), counts
//   mismatches (saturating) and reports pass/fail once the sweep completes.
//
//   Ports:
//     clk, rst          rising-edge clock, async active-high reset
//     start             begin a sweep (only in IDLE/DONE)
//     in_valid/in_ready sample handshake; in_ready high in every RUN cycle
//     in_a, in_b        operands applied to the comparator
//     in_gt/lt/eq       comparator response
//     busy              sweep in progress
//     done, pass        sweep complete and its verdict (held until start/rst)
//     seq_err           sticky out-of-order flag
//     err_count         saturating mismatch count
//     vec_count         samples accepted this sweep (wraps to 0 at the end)
//
//   Optional build macro FIRST_FAIL_CAPTURE_EN adds ff_valid/ff_a/ff_b/ff_resp,
//   which hold the operands and response of the first mismatch in a sweep.
module comparator_response_checker
  import comparator_chk_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_gt,
  input  logic                 in_lt,
  input  logic                 in_eq,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 seq_err,
  output logic [CNT_W-1:0]     err_count,
  output logic [2*WIDTH-1:0]   vec_count
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic                 ff_valid,
  output logic [WIDTH-1:0]     ff_a,
  output logic [WIDTH-1:0]     ff_b,
  output logic [RESP_W-1:0]    ff_resp
`endif
);

  localparam int VW = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [VW-1:0]      vec_q, vec_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               seq_q, seq_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic [RESP_W-1:0]  exp_resp;
  logic [RESP_W-1:0]  dut_resp;
  logic               accept;
  logic               mismatch;
  logic               order_bad;
  logic               last_vec;
  logic               enter_run;

  comparator_golden_model #(.WIDTH(WIDTH)) u_golden (
    .a_i    (in_a),
    .b_i    (in_b),
    .resp_o (exp_resp)
  );

  always_comb begin
    dut_resp         = '0;
    dut_resp[GT_BIT] = in_gt;
    dut_resp[LT_BIT] = in_lt;
    dut_resp[EQ_BIT] = in_eq;
  end

  assign in_ready  = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign accept    = in_valid & in_ready;
  // Full-word compare so non-one-hot responses (e.g. gt&eq) are caught too.
  assign mismatch  = (dut_resp != exp_resp);
  // The sweep index doubles as the expected {A,B} vector.
  assign order_bad = ({in_a, in_b} != vec_q);
  assign last_vec  = (vec_q == {VW{1'b1}});
  assign enter_run = start & (state_q != RUN);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    seq_d   = seq_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = '0;
          err_d   = '0;
          seq_d   = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          vec_d = vec_q + 1'b1;  // wraps to 0 on the final sample
          if (mismatch && (err_q != {CNT_W{1'b1}})) err_d = err_q + 1'b1;
          if (order_bad) seq_d = 1'b1;
          if (last_vec) begin
            state_d = DONE;
            done_d  = 1'b1;
            // Verdict uses next-state values so the final sample counts.
            pass_d  = (err_d == '0) && !seq_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      seq_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      seq_q   <= seq_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign seq_err   = seq_q;
  assign err_count = err_q;
  assign vec_count = vec_q;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic              ffv_q, ffv_d;
  logic [WIDTH-1:0]  ffa_q, ffa_d;
  logic [WIDTH-1:0]  ffb_q, ffb_d;
  logic [RESP_W-1:0] ffr_q, ffr_d;

  always_comb begin
    ffv_d = ffv_q;
    ffa_d = ffa_q;
    ffb_d = ffb_q;
    ffr_d = ffr_q;
    if (enter_run) begin
      ffv_d = 1'b0;
      ffa_d = '0;
      ffb_d = '0;
      ffr_d = '0;
    end else if (accept && mismatch && !ffv_q) begin
      // Only the first failure of a sweep is kept.
      ffv_d = 1'b1;
      ffa_d = in_a;
      ffb_d = in_b;
      ffr_d = dut_resp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ffv_q <= 1'b0;
      ffa_q <= '0;
      ffb_q <= '0;
      ffr_q <= '0;
    end else begin
      ffv_q <= ffv_d;
      ffa_q <= ffa_d;
      ffb_q <= ffb_d;
      ffr_q <= ffr_d;
    end
  end

  assign ff_valid = ffv_q;
  assign ff_a     = ffa_q;
  assign ff_b     = ffb_q;
  assign ff_resp  = ffr_q;
`else
  logic unused_enter_run;
  assign unused_enter_run = enter_run;
`endif

endmodule
